// File: rtl/regfile_write_arbiter.sv
// regfile_write_arbiter
// Shares the single register-file write port between the writeback stage (A)
// and the load-return path (B). B requests are buffered in an in-order FIFO,
// A has priority except when B has been starved for STARVE_LIMIT grants.
// The write port is registered: a grant at edge t writes during cycle t+1.

module regfile_write_arbiter #(
    parameter int FIFO_DEPTH   = 4,
    parameter int STARVE_LIMIT = 3
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        a_valid,
    input  logic [3:0]                  a_reg,
    input  logic [15:0]                 a_data,
    output logic                        a_ready,
    input  logic                        b_valid,
    input  logic [3:0]                  b_reg,
    input  logic [15:0]                 b_data,
    output logic                        b_ready,
    output logic                        WriteReg,
    output logic [3:0]                  DstReg,
    output logic [15:0]                 DstData,
    output logic [15:0]                 busy,
    output logic [$clog2(FIFO_DEPTH):0] fifo_count
);

    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;
    localparam int SW = $clog2(STARVE_LIMIT + 1);

    logic [3:0]    r_q_reg  [FIFO_DEPTH];
    logic [15:0]   r_q_data [FIFO_DEPTH];
    logic [PW-1:0] r_wptr;
    logic [PW-1:0] r_rptr;
    logic [CW-1:0] r_count;
    logic [SW-1:0] r_starve;
    logic          r_we;
    logic [3:0]    r_dst_reg;
    logic [15:0]   r_dst_data;

    logic          w_empty;
    logic          w_full;
    logic          w_starve;
    logic          w_a_grant;
    logic          w_b_grant;
    logic          w_push;
    logic [15:0]   w_busy;

    assign w_empty   = (r_count == '0);
    assign w_full    = (r_count == CW'(FIFO_DEPTH));
    assign w_starve  = (r_starve == SW'(STARVE_LIMIT)) && !w_empty;
    assign w_a_grant = a_valid && !w_starve;
    assign w_b_grant = !w_empty && !w_a_grant;
    // Writes to r0 are acknowledged but never occupy a slot.
    assign w_push    = b_valid && !w_full && (b_reg != '0);

    assign a_ready    = !w_starve;
    assign b_ready    = !w_full;
    assign WriteReg   = r_we;
    assign DstReg     = r_dst_reg;
    assign DstData    = r_dst_data;
    assign busy       = w_busy;
    assign fifo_count = r_count;

    // Busy vector: OR of the destination of every occupied slot, walked from the head.
    always_comb begin
        w_busy = '0;
        for (int unsigned i = 0; i < FIFO_DEPTH; i++) begin
            if (CW'(i) < r_count) begin
                w_busy[r_q_reg[r_rptr + PW'(i)]] = 1'b1;
            end
        end
    end

    // FIFO storage: payload only, occupancy is tracked by the pointers.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_q_reg[r_wptr]  <= b_reg;
            r_q_data[r_wptr] <= b_data;
        end
    end

    // FIFO pointers and occupancy count.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) begin
                r_wptr <= r_wptr + PW'(1);
            end
            if (w_b_grant) begin
                r_rptr <= r_rptr + PW'(1);
            end
            if (w_push && !w_b_grant) begin
                r_count <= r_count + CW'(1);
            end else if (!w_push && w_b_grant) begin
                r_count <= r_count - CW'(1);
            end
        end
    end

    // Consecutive A grants while B waits; saturating.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_starve <= '0;
        end else if (w_b_grant || w_empty) begin
            r_starve <= '0;
        end else if (w_a_grant && (r_starve != SW'(STARVE_LIMIT))) begin
            r_starve <= r_starve + SW'(1);
        end
    end

    // Registered write port; a dropped r0 write leaves address/data untouched.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_we       <= 1'b0;
            r_dst_reg  <= '0;
            r_dst_data <= '0;
        end else if (w_a_grant) begin
            r_we <= (a_reg != '0);
            if (a_reg != '0) begin
                r_dst_reg  <= a_reg;
                r_dst_data <= a_data;
            end
        end else if (w_b_grant) begin
            r_we       <= 1'b1;
            r_dst_reg  <= r_q_reg[r_rptr];
            r_dst_data <= r_q_data[r_rptr];
        end else begin
            r_we <= 1'b0;
        end
    end

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// tb_regfile_write_arbiter
// Two DUTs (STARVE_LIMIT 3 and 15) share one stimulus stream. A queue-based
// model predicts every output each cycle; directed literals pin the model.

module tb_regfile_write_arbiter;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        a_valid, b_valid;
    logic [3:0]  a_reg, b_reg;
    logic [15:0] a_data, b_data;

    logic [1:0]       a_ready, b_ready, we;
    logic [1:0][3:0]  dreg;
    logic [1:0][15:0] dd, busy;
    logic [1:0][2:0]  cnt;

    regfile_write_arbiter #(.FIFO_DEPTH(4), .STARVE_LIMIT(3)) dut0 (
        .clk(clk), .rst(rst),
        .a_valid(a_valid), .a_reg(a_reg), .a_data(a_data), .a_ready(a_ready[0]),
        .b_valid(b_valid), .b_reg(b_reg), .b_data(b_data), .b_ready(b_ready[0]),
        .WriteReg(we[0]), .DstReg(dreg[0]), .DstData(dd[0]),
        .busy(busy[0]), .fifo_count(cnt[0])
    );

    regfile_write_arbiter #(.FIFO_DEPTH(4), .STARVE_LIMIT(15)) dut1 (
        .clk(clk), .rst(rst),
        .a_valid(a_valid), .a_reg(a_reg), .a_data(a_data), .a_ready(a_ready[1]),
        .b_valid(b_valid), .b_reg(b_reg), .b_data(b_data), .b_ready(b_ready[1]),
        .WriteReg(we[1]), .DstReg(dreg[1]), .DstData(dd[1]),
        .busy(busy[1]), .fifo_count(cnt[1])
    );

    int passed = 0;
    int total  = 0;
    bit run    = 1'b0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    endtask

    // ---------------- behavioural model ----------------
    logic [19:0] mq [2][$];
    int          mscnt [2];
    logic        mwe   [2];
    logic [3:0]  mdreg [2];
    logic [15:0] mdd   [2];

    function automatic int lim(input int k);
        return (k == 0) ? 3 : 15;
    endfunction

    always @(posedge clk or posedge rst) begin
        bit emp, ful, stv, ag, bg;
        logic [19:0] e;
        for (int k = 0; k < 2; k++) begin
            if (rst) begin
                mq[k].delete();
                mscnt[k] = 0;
                mwe[k]   = 1'b0;
                mdreg[k] = 4'd0;
                mdd[k]   = 16'd0;
            end else begin
                emp = (mq[k].size() == 0);
                ful = (mq[k].size() == 4);
                stv = (mscnt[k] == lim(k)) && !emp;
                ag  = a_valid && !stv;
                bg  = !emp && !ag;
                if (ag) begin
                    mwe[k] = (a_reg != 4'd0);
                    if (a_reg != 4'd0) begin
                        mdreg[k] = a_reg;
                        mdd[k]   = a_data;
                    end
                end else if (bg) begin
                    e = mq[k].pop_front();
                    mwe[k]   = 1'b1;
                    mdreg[k] = e[19:16];
                    mdd[k]   = e[15:0];
                end else begin
                    mwe[k] = 1'b0;
                end
                if (bg || emp) mscnt[k] = 0;
                else if (ag && mscnt[k] < lim(k)) mscnt[k] = mscnt[k] + 1;
                if (b_valid && !ful && b_reg != 4'd0) mq[k].push_back({b_reg, b_data});
            end
        end
    end

    // Per-cycle comparison of both DUTs against the model.
    always @(negedge clk) begin
        logic [15:0] eb;
        bit stv;
        if (run && !rst) begin
            for (int k = 0; k < 2; k++) begin
                eb = '0;
                for (int i = 0; i < mq[k].size(); i++) eb[mq[k][i][19:16]] = 1'b1;
                stv = (mscnt[k] == lim(k)) && (mq[k].size() != 0);
                chk($sformatf("dut%0d WriteReg", k), {31'd0, we[k]}, {31'd0, mwe[k]});
                chk($sformatf("dut%0d DstReg", k), {28'd0, dreg[k]}, {28'd0, mdreg[k]});
                chk($sformatf("dut%0d DstData", k), {16'd0, dd[k]}, {16'd0, mdd[k]});
                chk($sformatf("dut%0d busy", k), {16'd0, busy[k]}, {16'd0, eb});
                chk($sformatf("dut%0d fifo_count", k), {29'd0, cnt[k]}, mq[k].size());
                chk($sformatf("dut%0d a_ready", k), {31'd0, a_ready[k]}, {31'd0, !stv});
                chk($sformatf("dut%0d b_ready", k), {31'd0, b_ready[k]}, {31'd0, mq[k].size() < 4});
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1);
    end

    // ---------------- directed stimulus ----------------
    initial begin
        rst = 1'b1; a_valid = 0; b_valid = 0;
        a_reg = 0; b_reg = 0; a_data = 0; b_data = 0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        run = 1'b1;

        // A only
        a_valid = 1; a_reg = 4'd3; a_data = 16'hBEEF;
        step();
        a_valid = 0;
        chk("A WriteReg t+1", {31'd0, we[0]}, 1);
        chk("A DstReg t+1", {28'd0, dreg[0]}, 3);
        chk("A DstData t+1", {16'd0, dd[0]}, 32'hBEEF);
        step();
        chk("A WriteReg t+2", {31'd0, we[0]}, 0);

        // B only
        b_valid = 1; b_reg = 4'd5; b_data = 16'h1234;
        step();
        b_valid = 0;
        chk("B busy t+1", {16'd0, busy[0]}, 32'h0020);
        chk("B count t+1", {29'd0, cnt[0]}, 1);
        chk("B WriteReg t+1", {31'd0, we[0]}, 0);
        step();
        chk("B WriteReg t+2", {31'd0, we[0]}, 1);
        chk("B DstReg t+2", {28'd0, dreg[0]}, 5);
        chk("B DstData t+2", {16'd0, dd[0]}, 32'h1234);
        chk("B busy t+2", {16'd0, busy[0]}, 0);
        chk("B count t+2", {29'd0, cnt[0]}, 0);

        // Starvation with STARVE_LIMIT=3
        a_valid = 1; a_reg = 4'd7; a_data = 16'hA000;
        b_valid = 1; b_reg = 4'd9; b_data = 16'h9999;
        step();
        b_valid = 0;
        chk("starve count queued", {29'd0, cnt[0]}, 1);
        chk("starve a_ready 0", {31'd0, a_ready[0]}, 1);
        step(); step();
        chk("starve a_ready 2", {31'd0, a_ready[0]}, 1);
        step();
        chk("starve a_ready 3", {31'd0, a_ready[0]}, 0);
        chk("starve 3rd A reg", {28'd0, dreg[0]}, 7);
        step();
        chk("starve B reg", {28'd0, dreg[0]}, 9);
        chk("starve B data", {16'd0, dd[0]}, 32'h9999);
        chk("starve a_ready back", {31'd0, a_ready[0]}, 1);
        step();
        chk("starve A resumes", {28'd0, dreg[0]}, 7);
        a_valid = 0;
        repeat (4) step();

        // Full / drain with STARVE_LIMIT=15
        a_valid = 1; a_reg = 4'd8; a_data = 16'h8888;
        b_valid = 1;
        for (int r = 1; r <= 4; r++) begin
            b_reg = 4'(r); b_data = 16'h1110 + 16'(r);
            step();
        end
        chk("full count", {29'd0, cnt[1]}, 4);
        chk("full b_ready", {31'd0, b_ready[1]}, 0);
        chk("full busy", {16'd0, busy[1]}, 32'h001E);
        b_reg = 4'd6; b_data = 16'h6666;
        step();
        chk("5th push count", {29'd0, cnt[1]}, 4);
        chk("5th push busy", {16'd0, busy[1]}, 32'h001E);
        chk("5th push A reg", {28'd0, dreg[1]}, 8);
        a_valid = 0; b_valid = 0;
        for (int r = 1; r <= 4; r++) begin
            step();
            chk("drain WriteReg", {31'd0, we[1]}, 1);
            chk("drain DstReg", {28'd0, dreg[1]}, r);
            chk("drain DstData", {16'd0, dd[1]}, 32'h1110 + r);
            chk("drain count", {29'd0, cnt[1]}, 4 - r);
            chk("drain b_ready", {31'd0, b_ready[1]}, 1);
        end
        repeat (4) step();

        // Register 0 drops
        a_valid = 1; a_reg = 4'd0; a_data = 16'hDEAD;
        step();
        a_valid = 0;
        chk("r0 A WriteReg", {31'd0, we[0]}, 0);
        chk("r0 A DstReg hold", {28'd0, dreg[0]}, 4);
        chk("r0 A DstData hold", {16'd0, dd[0]}, 32'h1114);
        b_valid = 1; b_reg = 4'd0; b_data = 16'h5555;
        chk("r0 B b_ready", {31'd0, b_ready[0]}, 1);
        step();
        b_valid = 0;
        chk("r0 B count", {29'd0, cnt[0]}, 0);
        chk("r0 B busy", {16'd0, busy[0]}, 0);
        step();
        chk("r0 B WriteReg", {31'd0, we[0]}, 0);

        // Mixed pattern: duplicate registers, simultaneous push/pop, wrap
        for (int i = 0; i < 60; i++) begin
            a_valid = (i % 3 != 0);
            a_reg   = 4'(i % 5);
            a_data  = 16'(i * 257);
            b_valid = (i % 4 != 3);
            b_reg   = 4'((i % 3) + 1);
            b_data  = 16'hC000 + 16'(i);
            step();
        end
        a_valid = 0; b_valid = 0;
        repeat (8) step();

        // Asynchronous reset mid-cycle
        a_valid = 1; a_reg = 4'd6; a_data = 16'h6006;
        b_valid = 1; b_reg = 4'd2; b_data = 16'h2002;
        step();
        a_valid = 0; b_valid = 0;
        chk("pre-reset WriteReg", {31'd0, we[0]}, 1);
        chk("pre-reset count", {29'd0, cnt[0]}, 1);
        #2 rst = 1'b1;
        #1;
        for (int k = 0; k < 2; k++) begin
            chk("rst WriteReg", {31'd0, we[k]}, 0);
            chk("rst DstReg", {28'd0, dreg[k]}, 0);
            chk("rst DstData", {16'd0, dd[k]}, 0);
            chk("rst busy", {16'd0, busy[k]}, 0);
            chk("rst count", {29'd0, cnt[k]}, 0);
            chk("rst b_ready", {31'd0, b_ready[k]}, 1);
        end
        @(posedge clk);
        #1 rst = 1'b0;
        step();
        chk("post-reset WriteReg", {31'd0, we[0]}, 0);
        chk("post-reset count", {29'd0, cnt[0]}, 0);
        step();

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
